// File: rtl/fhp_disp_pkg.sv
// Shared definitions for the FHP display path.
//   fhp_state_e : frame painter FSM encoding
//   VGA_W/VGA_H : framebuffer geometry in pixels
//   RGB_POP*    : RGB332 colour per cell-state popcount (particle density)
//   popcount6   : number of occupied channels in a 6-bit FHP cell state
package fhp_disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WT,
    ST_LD,
    ST_PAINT,
    ST_DONE
  } fhp_state_e;

  localparam int VGA_W = 640;
  localparam int VGA_H = 480;

  localparam logic [7:0] RGB_POP0 = 8'h00;
  localparam logic [7:0] RGB_POP1 = 8'hFF;
  localparam logic [7:0] RGB_POP2 = 8'hFC;
  localparam logic [7:0] RGB_POP3 = 8'hF8;
  localparam logic [7:0] RGB_POP4 = 8'hF4;
  localparam logic [7:0] RGB_POP5 = 8'hF0;
  localparam logic [7:0] RGB_POP6 = 8'hEC;

  function automatic logic [2:0] popcount6(input logic [5:0] s);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) n = n + 3'(s[i]);
    return n;
  endfunction

endpackage

// File: rtl/fhp_frame_painter_if.sv
// Painter bus: cell-state memory read port plus framebuffer pixel write port.
//   master : painter side (drives read strobe/address and pixel request)
//   slave  : memory / framebuffer-arbiter side
interface fhp_frame_painter_if #(
  parameter int ADDR_W      = 15,
  parameter int COLOR_NBITS = 8
);
  logic                   cell_rd_en;
  logic [ADDR_W-1:0]      cell_rd_addr;
  logic [5:0]             cell_rd_data;
  logic                   pix_wr_req;
  logic [9:0]             pix_x;
  logic [8:0]             pix_y;
  logic [COLOR_NBITS-1:0] pix_color;
  logic                   pix_wr_ack;

  modport master (
    output cell_rd_en, cell_rd_addr,
    input  cell_rd_data,
    output pix_wr_req, pix_x, pix_y, pix_color,
    input  pix_wr_ack
  );

  modport slave (
    input  cell_rd_en, cell_rd_addr,
    output cell_rd_data,
    input  pix_wr_req, pix_x, pix_y, pix_color,
    output pix_wr_ack
  );
endinterface

// File: rtl/fhp_frame_painter_color.sv
// Colour mapper: FHP cell state -> RGB332 colour by particle count.
//   cell_state : 6-bit occupancy vector
//   color      : colour, resized to color_nbits
module fhp_color_map
  import fhp_disp_pkg::*;
#(
  parameter int color_nbits = 8
) (
  input  logic [5:0]             cell_state,
  output logic [color_nbits-1:0] color
);
  logic [7:0] rgb;

  always_comb begin
    rgb = RGB_POP0;
    case (popcount6(cell_state))
      3'd1:    rgb = RGB_POP1;
      3'd2:    rgb = RGB_POP2;
      3'd3:    rgb = RGB_POP3;
      3'd4:    rgb = RGB_POP4;
      3'd5:    rgb = RGB_POP5;
      3'd6:    rgb = RGB_POP6;
      default: rgb = RGB_POP0;
    endcase
  end

  assign color = color_nbits'(rgb);
endmodule

// File: rtl/fhp_frame_painter.sv
// FHP frame painter: on start, reads every lattice cell in raster order,
// maps it to a colour and writes it as a SCALE x SCALE pixel block.
//   clk, reset_n : clock, synchronous active-low reset
//   start        : frame trigger (honoured only when idle)
//   busy, done   : frame in progress / one-cycle end-of-frame pulse
//   frame_cnt    : completed frame counter (wraps)
//   bus          : cell read port + pixel req/ack write port (master)
module fhp_frame_painter
  import fhp_disp_pkg::*;
#(
  parameter int LAT_W       = 160,
  parameter int LAT_H       = 120,
  parameter int SCALE       = 4,
  parameter int ADDR_W      = 15,
  parameter int COLOR_NBITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [15:0]         frame_cnt,
  fhp_frame_painter_if.master bus
);
  localparam int CX_W  = (LAT_W > 1) ? $clog2(LAT_W) : 1;
  localparam int CY_W  = (LAT_H > 1) ? $clog2(LAT_H) : 1;
  localparam int SHIFT = $clog2(SCALE);
  localparam int S_W   = (SCALE > 1) ? SHIFT : 1;

  localparam logic [CX_W-1:0] CX_LAST = CX_W'(LAT_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(LAT_H - 1);
  localparam logic [S_W-1:0]  S_LAST  = S_W'(SCALE - 1);

  fhp_state_e state_q, state_d;

  logic [CX_W-1:0]        cx;
  logic [CY_W-1:0]        cy;
  logic [S_W-1:0]         sx, sy;
  logic [5:0]             cell_q;
  logic [15:0]            frame_cnt_q;
  logic [COLOR_NBITS-1:0] color_w;
  logic                   sub_last, cell_last;

  assign sub_last  = (sx == S_LAST) && (sy == S_LAST);
  assign cell_last = (cx == CX_LAST) && (cy == CY_LAST);

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    done           = 1'b0;
    bus.cell_rd_en = 1'b0;
    bus.pix_wr_req = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RD;
      ST_RD: begin
        bus.cell_rd_en = 1'b1;
        state_d        = ST_WT;
      end
      ST_WT:    state_d = ST_LD;
      ST_LD:    state_d = ST_PAINT;
      ST_PAINT: begin
        bus.pix_wr_req = 1'b1;
        if (bus.pix_wr_ack && sub_last) state_d = cell_last ? ST_DONE : ST_RD;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // ---- cell / subpixel counters ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cx          <= '0;
      cy          <= '0;
      sx          <= '0;
      sy          <= '0;
      cell_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          cx <= '0;
          cy <= '0;
        end
        // Read data is valid during the latency cycle, so it is captured
        // on the edge that enters LD.
        ST_WT: begin
          cell_q <= bus.cell_rd_data;
          sx     <= '0;
          sy     <= '0;
        end
        ST_PAINT: if (bus.pix_wr_ack) begin
          if (sx == S_LAST) begin
            sx <= '0;
            if (sy == S_LAST) begin
              sy <= '0;
              if (cell_last) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
              end else if (cx == CX_LAST) begin
                cx <= '0;
                cy <= cy + 1'b1;
              end else begin
                cx <= cx + 1'b1;
              end
            end else begin
              sy <= sy + 1'b1;
            end
          end else begin
            sx <= sx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign frame_cnt = frame_cnt_q;

  // ---- address / pixel coordinates ----
  assign bus.cell_rd_addr = ADDR_W'(32'(cy) * 32'(LAT_W) + 32'(cx));
  assign bus.pix_x        = (10'(cx) << SHIFT) | 10'(sx);
  assign bus.pix_y        = (9'(cy) << SHIFT) | 9'(sy);

  fhp_color_map #(.color_nbits(COLOR_NBITS)) u_color (
    .cell_state (cell_q),
    .color      (color_w)
  );
  assign bus.pix_color = color_w;

  // Lattice must fit the VGA raster.
  always_ff @(posedge clk) begin
    if (reset_n)
      assert (LAT_W * SCALE <= VGA_W && LAT_H * SCALE <= VGA_H)
        else $error("lattice %0dx%0d at scale %0d exceeds VGA raster", LAT_W, LAT_H, SCALE);
  end
endmodule

// File: doc/fhp_frame_painter.md
Name: fhp_frame_painter

Overview:
Sequences the FHP display path. On each frame trigger it scans every lattice cell from the cell-state memory and maps each 6-bit cell state to an RGB332 colour through the Color mapper. It then paints the cell as a SCALE×SCALE pixel block into the VGA framebuffer over a req/ack write port. It sits between the simulation engine, which pulses start after a lattice step, and the VGA framebuffer write arbiter.

Parameters:
LAT_W, 160, lattice width in cells
LAT_H, 120, lattice height in cells
SCALE, 4, pixels per cell edge (power of two, 1..8)
ADDR_W, 15, cell address width, ≥ clog2(LAT_W*LAT_H)
COLOR_NBITS, 8, pixel colour width (RGB332)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle frame trigger; ignored unless idle
busy  out  1  high from the cycle after accepted start through DONE
done  out  1  one-cycle pulse when the last pixel of the frame is acked
frame_cnt  out  16  completed frames, wraps 0xFFFF→0
cell_rd_en  out  1  cell memory read strobe
cell_rd_addr  out  ADDR_W  cell address, cy*LAT_W+cx
cell_rd_data  in  6  cell state, valid exactly 1 cycle after cell_rd_en
pix_wr_req  out  1  pixel write request
pix_x  out  10  pixel column, cx*SCALE+sx
pix_y  out  9  pixel row, cy*SCALE+sy
pix_color  out  COLOR_NBITS  pixel colour
pix_wr_ack  in  1  write accepted in any cycle where req&ack

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State→IDLE.
  - All outputs and the internal cx/cy/sx/sy counters are 0, including frame_cnt.
  - Reset mid-frame abandons the frame with no done pulse.
- FSM states: IDLE, RD, WT, LD, PAINT, DONE.
- IDLE:
  - start=1 → RD with cx=cy=0.
  - busy rises on the next cycle.
- RD: cell_rd_en=1 for exactly one cycle, with cell_rd_addr = cy*LAT_W+cx → WT.
- WT: memory latency cycle → LD.
- LD:
  - cell_rd_data is registered into cell_q.
  - sx=sy=0 → PAINT.
- Colour mapping: pix_color = Color(cell_q), combinational from the registered state.
  - Popcount 0 → 0x00, 1 → 0xFF, 2 → 0xFC, 3 → 0xF8, 4 → 0xF4, 5 → 0xF0, 6 → 0xEC.
- PAINT request rules:
  - pix_wr_req=1; pix_x, pix_y and pix_color stay stable until ack.
  - ack may be high in the same cycle req rises.
  - Each req&ack advances sx; on sx wrap, sy advances.
  - At most one write per cycle.
- PAINT exit, on the ack of subpixel (SCALE-1, SCALE-1):
  - If cell is not last: advance cx (wrap to 0 and increment cy at LAT_W-1) → RD.
  - If cell is last (cx=LAT_W-1, cy=LAT_H-1) → DONE.
- DONE:
  - done=1 for one cycle; frame_cnt increments on the same edge it is entered.
  - Busy stays high during DONE → IDLE next cycle.
  - start during DONE or any non-IDLE state is dropped, not queued.
- Throughput: with ack held high, each cell costs 3+SCALE² cycles; a frame costs LAT_W*LAT_H*(3+SCALE²)+1 cycles after the start edge.
- Arithmetic:
  - pix_x and pix_y are computed with shifts (SCALE is a power of two) and zero-extended to 10/9 bits.
  - Parameter sets must satisfy LAT_W*SCALE ≤ 640 and LAT_H*SCALE ≤ 480; this is checked by a simulation-only assertion.
- Ack while req=0 is ignored.

Decomposition:
- Shared package fhp_disp_pkg holds:
  - state encodings;
  - VGA_W=640 and VGA_H=480;
  - the RGB332 colour constants used by Color.
- One natural sub-module: the existing Color mapper, instantiated with color_nbits=COLOR_NBITS and fed from cell_q.
- Counters and FSM stay in fhp_frame_painter.

Test Plan:
All scenarios use LAT_W=4, LAT_H=3, SCALE=2, ADDR_W=4.
1. Cell memory holds popcounts 0..6 cycling; start pulse; ack tied 1 → 48 writes in raster block order, cell (1,0) paints (2,0),(3,0),(2,1),(3,1) with 0xFF; done exactly 85 cycles after the start edge; frame_cnt=1.
2. Random ack (about 30% high) → req, pix_x, pix_y and pix_color never change while req&!ack; write multiset matches scenario 1; single done pulse.
3. Second start while busy, and one during DONE → no effect; exactly one frame written; frame_cnt=1.
4. reset_n=0 for one cycle after write #20 → next cycle all outputs 0 and state IDLE; no done pulse; a fresh start repaints from cell 0 with full 48 writes.
5. 65536 back-to-back frames (frame_cnt preloaded via force to 0xFFFF) → frame_cnt wraps to 0 on the next done.
6. cell_rd_data driven to garbage except in the cycle after cell_rd_en, with value 6'b111111 → pix_color=0xEC for all 4 subpixels.
